// File: rtl/physics_pkg.sv
// Shared physics types and defaults for the snapshot readback path.
// Optional build macro used by the snapshot reader: SNAPSHOT_CHECKSUM_EN.
package physics_pkg;

    localparam int PHYS_SPRITES    = 4;
    localparam int PHYS_DIMENSIONS = 2;
    localparam int PHYS_WIDTH      = 32;

    // One body's vector (location or velocity) across all axes.
    typedef logic [PHYS_DIMENSIONS-1:0][PHYS_WIDTH-1:0] vec_t;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } snap_state_t;

endpackage

// File: rtl/rising_edge_detector.sv
// Single-cycle pulse on a 0->1 transition of a level input.
// The history register resets to 0, so an input already high when reset
// releases is reported as an edge on the first clock after release.
module rising_edge_detector (
    input  logic clock_162,
    input  logic rst,
    input  logic in,
    output logic pulse
);

    logic r_prev;

    // Remember last cycle's input level.
    always_ff @(posedge clock_162 or posedge rst) begin
        if (rst) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= in;
        end
    end

    assign pulse = in & ~r_prev;

endmodule

// File: rtl/state_snapshot_reader.sv
// Freezes all sprite locations/velocities on a capture edge, then streams
// them one word per handshake (sprite-major; locations before velocities).
// Build macro SNAPSHOT_CHECKSUM_EN appends an XOR checksum word to each frame.
module state_snapshot_reader
    import physics_pkg::*;
#(
    parameter int SPRITES    = PHYS_SPRITES,
    parameter int DIMENSIONS = PHYS_DIMENSIONS,
    parameter int WIDTH      = PHYS_WIDTH,
    localparam int SW = (SPRITES > 1) ? $clog2(SPRITES) : 1,
    localparam int DW = (DIMENSIONS > 1) ? $clog2(DIMENSIONS) : 1,
    localparam int VW = SPRITES * DIMENSIONS * WIDTH
) (
    input  logic            clock_162,
    input  logic            rst,
    input  logic            capture,
    input  logic [VW-1:0]   locations,
    input  logic [VW-1:0]   velos,
    output logic [WIDTH-1:0] out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SW-1:0]   out_sprite,
    output logic [DW-1:0]   out_dim,
    output logic            out_is_vel,
    output logic            out_last,
    output logic            busy,
    output logic [VW-1:0]   snap_loc,
    output logic [VW-1:0]   snap_vel,
    output logic            snap_valid
);

    snap_state_t      r_state;
    snap_state_t      w_state_next;

    logic             w_capture_pulse;
    logic             w_start;
    logic             w_accept;
    logic             w_data_last;
    logic             w_frame_last;

    // Word position as nested counters: sprite, then loc/vel half, then axis.
    logic [SW-1:0]    r_sprite;
    logic [DW-1:0]    r_dim;
    logic             r_is_vel;

    logic [VW-1:0]    r_snap_loc;
    logic [VW-1:0]    r_snap_vel;
    logic             r_snap_valid;

    logic [WIDTH-1:0] w_loc_words [SPRITES][DIMENSIONS];
    logic [WIDTH-1:0] w_vel_words [SPRITES][DIMENSIONS];
    logic [WIDTH-1:0] w_word;

`ifdef SNAPSHOT_CHECKSUM_EN
    logic             r_csum_phase;
    logic [WIDTH-1:0] r_xor;
`endif

    rising_edge_detector u_capture_edge (
        .clock_162 (clock_162),
        .rst       (rst),
        .in        (capture),
        .pulse     (w_capture_pulse)
    );

    // Word-addressable views of the frozen snapshot.
    generate
        for (genvar gi = 0; gi < SPRITES; gi++) begin : g_sprite
            for (genvar gj = 0; gj < DIMENSIONS; gj++) begin : g_dim
                assign w_loc_words[gi][gj] = r_snap_loc[(gi*DIMENSIONS + gj)*WIDTH +: WIDTH];
                assign w_vel_words[gi][gj] = r_snap_vel[(gi*DIMENSIONS + gj)*WIDTH +: WIDTH];
            end
        end
    endgenerate

    assign w_word      = r_is_vel ? w_vel_words[r_sprite][r_dim] : w_loc_words[r_sprite][r_dim];
    assign w_start     = (r_state == IDLE) && w_capture_pulse;
    assign w_accept    = (r_state == STREAM) && out_ready;
    assign w_data_last = (r_sprite == SW'(SPRITES - 1)) && r_is_vel
                      && (r_dim == DW'(DIMENSIONS - 1));

`ifdef SNAPSHOT_CHECKSUM_EN
    assign w_frame_last = r_csum_phase;
`else
    assign w_frame_last = w_data_last;
`endif

    // State register.
    always_ff @(posedge clock_162 or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and stream outputs; outputs are idle-zero outside STREAM.
    always_comb begin
        w_state_next = r_state;
        out_valid    = 1'b0;
        out_data     = '0;
        out_sprite   = '0;
        out_dim      = '0;
        out_is_vel   = 1'b0;
        out_last     = 1'b0;
        busy         = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_capture_pulse) begin
                    w_state_next = STREAM;
                end
            end
            STREAM: begin
                busy       = 1'b1;
                out_valid  = 1'b1;
                out_data   = w_word;
                out_sprite = r_sprite;
                out_dim    = r_dim;
                out_is_vel = r_is_vel;
                out_last   = w_frame_last;
`ifdef SNAPSHOT_CHECKSUM_EN
                if (r_csum_phase) begin
                    out_data   = r_xor;
                    out_is_vel = 1'b1;
                end
`endif
                if (out_ready && w_frame_last) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Advance the word position on each accepted word; rewind when idle.
    always_ff @(posedge clock_162 or posedge rst) begin
        if (rst) begin
            r_sprite <= '0;
            r_dim    <= '0;
            r_is_vel <= 1'b0;
`ifdef SNAPSHOT_CHECKSUM_EN
            r_csum_phase <= 1'b0;
`endif
        end else if (r_state == IDLE || (w_accept && w_frame_last)) begin
            r_sprite <= '0;
            r_dim    <= '0;
            r_is_vel <= 1'b0;
`ifdef SNAPSHOT_CHECKSUM_EN
            r_csum_phase <= 1'b0;
        end else if (w_accept && w_data_last) begin
            // Park the position at zero so the checksum word carries sprite 0 / dim 0 tags.
            r_sprite     <= '0;
            r_dim        <= '0;
            r_is_vel     <= 1'b0;
            r_csum_phase <= 1'b1;
`endif
        end else if (w_accept) begin
            if (r_dim == DW'(DIMENSIONS - 1)) begin
                r_dim <= '0;
                if (r_is_vel) begin
                    r_is_vel <= 1'b0;
                    r_sprite <= r_sprite + 1'b1;
                end else begin
                    r_is_vel <= 1'b1;
                end
            end else begin
                r_dim <= r_dim + 1'b1;
            end
        end
    end

`ifdef SNAPSHOT_CHECKSUM_EN
    // Running XOR of every data word handed over in the current frame.
    always_ff @(posedge clock_162 or posedge rst) begin
        if (rst) begin
            r_xor <= '0;
        end else if (r_state == IDLE) begin
            r_xor <= '0;
        end else if (w_accept && !r_csum_phase) begin
            r_xor <= r_xor ^ w_word;
        end
    end
`endif

    // Freeze live physics state only when a frame is actually started.
    always_ff @(posedge clock_162 or posedge rst) begin
        if (rst) begin
            r_snap_loc   <= '0;
            r_snap_vel   <= '0;
            r_snap_valid <= 1'b0;
        end else if (w_start) begin
            r_snap_loc   <= locations;
            r_snap_vel   <= velos;
            r_snap_valid <= 1'b1;
        end
    end

    assign snap_loc   = r_snap_loc;
    assign snap_vel   = r_snap_vel;
    assign snap_valid = r_snap_valid;

endmodule

// File: tb/tb_state_snapshot_reader.sv
// Scoreboard bench for state_snapshot_reader: stimulus pushes expected words,
// a negedge monitor pops and compares on every accepted word.
module tb_state_snapshot_reader;

    localparam int S  = 4;
    localparam int D  = 2;
    localparam int W  = 32;
    localparam int VW = S * D * W;
`ifdef SNAPSHOT_CHECKSUM_EN
    localparam int FRAME = 2 * S * D + 1;
`else
    localparam int FRAME = 2 * S * D;
`endif

    typedef struct packed {
        logic [W-1:0] data;
        logic [1:0]   sprite;
        logic         dim;
        logic         is_vel;
        logic         last;
    } word_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          capture;
    logic [VW-1:0] locations;
    logic [VW-1:0] velos;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          out_ready;
    logic [1:0]    out_sprite;
    logic          out_dim;
    logic          out_is_vel;
    logic          out_last;
    logic          busy;
    logic [VW-1:0] snap_loc;
    logic [VW-1:0] snap_vel;
    logic          snap_valid;

    int checks = 0;
    int errors = 0;
    word_t exp_q[$];

    logic [VW-1:0] loc_a, vel_a, loc_b, loc_c;

    state_snapshot_reader dut (
        .clock_162  (clk),
        .rst        (rst),
        .capture    (capture),
        .locations  (locations),
        .velos      (velos),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sprite (out_sprite),
        .out_dim    (out_dim),
        .out_is_vel (out_is_vel),
        .out_last   (out_last),
        .busy       (busy),
        .snap_loc   (snap_loc),
        .snap_vel   (snap_vel),
        .snap_valid (snap_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Expected frame: sprite-major, location axes then velocity axes, optional XOR word.
    task automatic push_frame(input logic [VW-1:0] loc, input logic [VW-1:0] vel);
        word_t        w;
        logic [W-1:0] x;
        int           n;
        x = '0;
        n = 0;
        for (int s = 0; s < S; s++) begin
            for (int v = 0; v < 2; v++) begin
                for (int d = 0; d < D; d++) begin
                    w.data   = (v == 1) ? vel[(s*D + d)*W +: W] : loc[(s*D + d)*W +: W];
                    w.sprite = 2'(s);
                    w.dim    = 1'(d);
                    w.is_vel = 1'(v);
                    n++;
                    w.last   = (n == FRAME);
                    x        = x ^ w.data;
                    exp_q.push_back(w);
                end
            end
        end
`ifdef SNAPSHOT_CHECKSUM_EN
        w.data   = x;
        w.sprite = 2'd0;
        w.dim    = 1'b0;
        w.is_vel = 1'b1;
        w.last   = 1'b1;
        exp_q.push_back(w);
`endif
    endtask

    // Monitor: compares accepted words, stall stability and the return to idle.
    logic  prev_stall = 1'b0;
    logic  exp_idle   = 1'b0;
    word_t prev_word;
    always @(negedge clk) begin
        word_t cur;
        word_t e;
        cur = '{data: out_data, sprite: out_sprite, dim: out_dim, is_vel: out_is_vel, last: out_last};
        if (rst) begin
            prev_stall = 1'b0;
            exp_idle   = 1'b0;
        end else begin
            if (exp_idle) begin
                check("idle_after_last", VW'({busy, out_valid}), '0);
                exp_idle = 1'b0;
            end
            if (prev_stall) begin
                check("stall_hold", VW'({out_valid, cur}), VW'({1'b1, prev_word}));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %h expected none", cur);
                end else begin
                    e = exp_q.pop_front();
                    check("word", VW'(cur), VW'(e));
                    if (e.last) exp_idle = 1'b1;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_word  = cur;
        end
    end

    task automatic pulse_capture();
        @(posedge clk); #1 capture = 1'b1;
        @(posedge clk); #1 capture = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("frame_done_busy", VW'(busy), '0);
        @(negedge clk);
        check("queue_empty", VW'(exp_q.size()), '0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        for (int s = 0; s < S; s++) begin
            for (int d = 0; d < D; d++) begin
                loc_a[(s*D + d)*W +: W] = (s == 0) ? 32'h0100_0000
                                        : 32'h0100_0000 * (s + 1) + d * 32'h1000;
                vel_a[(s*D + d)*W +: W] = (s == 0) ? ((d == 0) ? 32'h0010_0000 : 32'h0)
                                        : (32'h8000_0000 | (s << 4) | d);
                loc_b[(s*D + d)*W +: W] = 32'hff00_0000 | (s << 8) | d;
                loc_c[(s*D + d)*W +: W] = 32'h1234_0000 | (s << 8) | d;
            end
        end

        // 1. Reset with capture held high; release counts as an edge.
        rst = 1'b1; capture = 1'b1; out_ready = 1'b1;
        locations = loc_a; velos = vel_a;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ctrl_zero", VW'({out_valid, busy, snap_valid, out_last, out_is_vel, out_sprite, out_dim}), '0);
        check("rst_data_zero", VW'(out_data), '0);
        check("rst_snap_loc", snap_loc, '0);
        check("rst_snap_vel", snap_vel, '0);
        push_frame(loc_a, vel_a);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("pre_edge_idle", VW'(out_valid), '0);
        @(negedge clk);
        check("first_word_latency", VW'({out_valid, out_data}), VW'({1'b1, 32'h0100_0000}));
        #1 capture = 1'b0;
        wait_idle();
        check("snap_valid_set", VW'(snap_valid), VW'(1));

        // 2. Full-rate frame from a fresh edge.
        push_frame(loc_a, vel_a);
        pulse_capture();
        wait_idle();
        check("snap_loc_a", snap_loc, loc_a);
        check("snap_vel_a", snap_vel, vel_a);

        // 3. Backpressure: ready toggles every cycle.
        push_frame(loc_a, vel_a);
        pulse_capture();
        n = 0;
        while (busy && n < 300) begin
            @(posedge clk); #1 out_ready = ~out_ready;
            n++;
        end
        check("bp_frame_done", VW'(busy), '0);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_queue_empty", VW'(exp_q.size()), '0);

        // 4. Capture during STREAM is dropped; a later idle edge takes new values.
        push_frame(loc_a, vel_a);
        pulse_capture();
        repeat (4) @(posedge clk);
        #1 locations = loc_b; capture = 1'b1;
        @(posedge clk); #1 capture = 1'b0;
        wait_idle();
        check("snap_kept_during_stream", snap_loc, loc_a);
        push_frame(loc_b, vel_a);
        pulse_capture();
        // Raise capture exactly on the final word's handshake cycle: must be ignored.
        n = 0;
        @(negedge clk);
        while (!out_last && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("saw_out_last", VW'(out_last), VW'(1));
        locations = loc_c;
        capture   = 1'b1;
        repeat (3) @(negedge clk);
        check("edge_at_return_ignored", VW'({busy, out_valid}), '0);
        check("snap_loc_b", snap_loc, loc_b);
        capture = 1'b0;
        @(negedge clk);
        check("queue_empty_b", VW'(exp_q.size()), '0);

        // 5. Reset while stalled mid-frame, then a clean full frame.
        push_frame(loc_c, vel_a);
        out_ready = 1'b0;
        pulse_capture();
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_ctrl", VW'({out_valid, busy, snap_valid}), '0);
        check("rst_mid_snap", snap_loc, '0);
        exp_q.delete();
        @(posedge clk); #1 rst = 1'b0; out_ready = 1'b1;
        push_frame(loc_c, vel_a);
        pulse_capture();
        wait_idle();
        check("snap_loc_c", snap_loc, loc_c);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
